// File: rtl/ldpc_dvb_enc_sink_pkg.sv
// Shared types for the DVB LDPC encoder output sink: FSM states, skid FIFO
// sizing and the sop/eop strobe pair carried alongside each data word.
package ldpc_dvb_enc_sink_pkg;

    localparam int cSINK_FIFO_DEPTH = 4;
    localparam int cSINK_PTR_W      = $clog2(cSINK_FIFO_DEPTH);
    localparam int cSINK_CNT_W      = cSINK_PTR_W + 1;
    localparam int cBUF_ADDR_W      = 12;

    typedef logic [cBUF_ADDR_W-1:0] buf_addr_t;

    typedef struct packed {
        logic sop;
        logic eop;
    } sink_strb_t;

    typedef enum logic [2:0] {
        cRESET_STATE,
        cWAIT_STATE,
        cINIT_STATE,
        cREAD_STATE,
        cFLUSH_STATE,
        cDONE_STATE
    } sink_state_t;

endpackage

// File: rtl/ldpc_dvb_enc_sink_fifo.sv
// Four-entry show-ahead register FIFO holding data words plus sop/eop strobes;
// the head entry is driven straight from storage so outputs are registered.
module ldpc_dvb_enc_sink_fifo
    import ldpc_dvb_enc_sink_pkg::*;
#(
    parameter int pDAT_W = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic                   push_i,
    input  logic [pDAT_W-1:0]      data_i,
    input  sink_strb_t             strb_i,
    input  logic                   pop_i,
    output logic [pDAT_W-1:0]      data_o,
    output sink_strb_t             strb_o,
    output logic [cSINK_CNT_W-1:0] cnt_o,
    output logic                   empty_o
);

    logic [pDAT_W-1:0]      dat_q  [cSINK_FIFO_DEPTH];
    sink_strb_t             strb_q [cSINK_FIFO_DEPTH];
    logic [cSINK_PTR_W-1:0] wrPtr_q, rdPtr_q;
    logic [cSINK_CNT_W-1:0] cnt_q;
    logic                   doPush, doPop;

    // Guards keep the pointers coherent even if a caller misbehaves.
    assign doPush = push_i && (cnt_q != cSINK_CNT_W'(cSINK_FIFO_DEPTH));
    assign doPop  = pop_i && (cnt_q != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < cSINK_FIFO_DEPTH; i++) begin
                dat_q[i]  <= '0;
                strb_q[i] <= '0;
            end
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            cnt_q   <= '0;
        end else if (en_i) begin
            if (doPush) begin
                dat_q[wrPtr_q]  <= data_i;
                strb_q[wrPtr_q] <= strb_i;
                wrPtr_q         <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            if (doPush && !doPop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!doPush && doPop) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign data_o  = dat_q[rdPtr_q];
    assign strb_o  = strb_q[rdPtr_q];
    assign cnt_o   = cnt_q;
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/ldpc_dvb_enc_sink.sv
// Encoder output sink: drains one codeword from the output ping-pong bank and
// streams it downstream over valid/ready, releasing the bank once fully read.
module ldpc_dvb_enc_sink
    import ldpc_dvb_enc_sink_pkg::*;
#(
    parameter int pDAT_W  = 8,
    parameter int pADDR_W = 12,
    parameter int pRD_LAT = 2,
    parameter int pTAG_W  = 4
) (
    input  logic               iclk,
    input  logic               ireset,
    input  logic               iclkena,
    input  logic               ibuf_full,
    input  logic [pADDR_W-1:0] ilen,
    input  logic [pTAG_W-1:0]  itag,
    output logic               obuf_empty,
    output logic [pADDR_W-1:0] oraddr,
    output logic               oread,
    input  logic [pDAT_W-1:0]  irdat,
    input  logic               ireq,
    output logic               oval,
    output logic               osop,
    output logic               oeop,
    output logic [pDAT_W-1:0]  odat,
    output logic [pTAG_W-1:0]  otag,
    output logic               obusy
);

    sink_state_t            state_q, state_d;
    logic [pADDR_W-1:0]     len_q, len_d;
    logic [pADDR_W-1:0]     addr_q, addr_d;
    logic [pTAG_W-1:0]      tag_q, tag_d;
    logic                   busy_q, busy_d;
    logic                   bufEmpty_q, bufEmpty_d;
    logic [pRD_LAT-1:0]     dlVld_q, dlSop_q, dlEop_q;

    logic [2:0]             inflight;
    logic [cSINK_CNT_W-1:0] fifoCnt;
    logic                   rdEn, push, pop, fifoEmpty;
    sink_strb_t             pushStrb, headStrb;
    logic [pDAT_W-1:0]      headDat;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < pRD_LAT; i++) begin
            inflight = inflight + 3'(dlVld_q[i]);
        end
    end

    // A read is only issued when its word is guaranteed a FIFO slot on return.
    assign rdEn = (state_q == cREAD_STATE) &&
                  ((4'(fifoCnt) + 4'(inflight)) < 4'(cSINK_FIFO_DEPTH));

    assign push     = dlVld_q[pRD_LAT-1];
    assign pushStrb = '{sop: dlSop_q[pRD_LAT-1], eop: dlEop_q[pRD_LAT-1]};
    assign pop      = !fifoEmpty && ireq;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        tag_d      = tag_q;
        addr_d     = addr_q;
        busy_d     = busy_q;
        bufEmpty_d = push && pushStrb.eop;
        case (state_q)
            cRESET_STATE: state_d = cWAIT_STATE;
            cWAIT_STATE: begin
                if (ibuf_full) begin
                    state_d = cINIT_STATE;
                    busy_d  = 1'b1;
                end
            end
            cINIT_STATE: begin
                len_d   = ilen;
                tag_d   = itag;
                addr_d  = '0;
                state_d = cREAD_STATE;
            end
            cREAD_STATE: begin
                if (rdEn) begin
                    addr_d = addr_q + 1'b1;
                    if (addr_q == len_q) begin
                        state_d = cFLUSH_STATE;
                    end
                end
            end
            cFLUSH_STATE: begin
                if ((inflight == '0) && fifoEmpty) begin
                    state_d = cDONE_STATE;
                end
            end
            cDONE_STATE: state_d = cWAIT_STATE;
            default:     state_d = cRESET_STATE;
        endcase
        if (pop && headStrb.eop) begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            state_q    <= cRESET_STATE;
            len_q      <= '0;
            addr_q     <= '0;
            tag_q      <= '0;
            busy_q     <= 1'b0;
            bufEmpty_q <= 1'b0;
            dlVld_q    <= '0;
            dlSop_q    <= '0;
            dlEop_q    <= '0;
        end else if (iclkena) begin
            state_q    <= state_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            tag_q      <= tag_d;
            busy_q     <= busy_d;
            bufEmpty_q <= bufEmpty_d;
            // Delay line mirrors the RAM latency so each word returns tagged.
            dlVld_q[0] <= rdEn;
            dlSop_q[0] <= (addr_q == '0);
            dlEop_q[0] <= (addr_q == len_q);
            for (int i = 1; i < pRD_LAT; i++) begin
                dlVld_q[i] <= dlVld_q[i-1];
                dlSop_q[i] <= dlSop_q[i-1];
                dlEop_q[i] <= dlEop_q[i-1];
            end
        end
    end

    ldpc_dvb_enc_sink_fifo #(
        .pDAT_W (pDAT_W)
    ) uFifo (
        .clk_i   (iclk),
        .rst_i   (ireset),
        .en_i    (iclkena),
        .push_i  (push),
        .data_i  (irdat),
        .strb_i  (pushStrb),
        .pop_i   (pop),
        .data_o  (headDat),
        .strb_o  (headStrb),
        .cnt_o   (fifoCnt),
        .empty_o (fifoEmpty)
    );

    assign oread      = rdEn;
    assign oraddr     = addr_q;
    assign oval       = !fifoEmpty;
    assign osop       = headStrb.sop;
    assign oeop       = headStrb.eop;
    assign odat       = headDat;
    assign otag       = tag_q;
    assign obusy      = busy_q;
    assign obuf_empty = bufEmpty_q;

endmodule

// File: tb/tb_ldpc_dvb_enc_sink.sv
// Scoreboard bench for ldpc_dvb_enc_sink: a RAM model feeds random codewords,
// expected words are queued per frame and a monitor checks every accepted word.
module tb_ldpc_dvb_enc_sink;

    localparam int DW  = 8;
    localparam int AW  = 12;
    localparam int LAT = 2;
    localparam int TW  = 4;

    logic          iclk = 1'b0;
    logic          ireset = 1'b1;
    logic          iclkena = 1'b1;
    logic          ibuf_full = 1'b0;
    logic [AW-1:0] ilen = '0;
    logic [TW-1:0] itag = '0;
    logic [DW-1:0] irdat;
    logic          ireq = 1'b0;
    logic          obuf_empty, oread, oval, osop, oeop, obusy;
    logic [AW-1:0] oraddr;
    logic [DW-1:0] odat;
    logic [TW-1:0] otag;

    typedef struct packed {
        logic [DW-1:0] dat;
        logic          sop;
        logic          eop;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t          expQ[$];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            reqMode = 0;
    int            enaRandom = 0;
    int            holdStart = 0;
    int            pulseCnt = 0;
    int            eopSeen = 0;
    int            acceptCnt = 0;
    int            outstanding = 0;
    bit            checkBusyLow = 0;
    bit            prevEmpty = 0;
    bit            enaPrev = 0;
    bit            holdPending = 0;
    logic [DW-1:0] holdDat;
    logic          holdSop, holdEop;

    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] ramPipe [LAT];

    always #5 iclk = ~iclk;

    ldpc_dvb_enc_sink #(
        .pDAT_W  (DW),
        .pADDR_W (AW),
        .pRD_LAT (LAT),
        .pTAG_W  (TW)
    ) dut (
        .iclk       (iclk),
        .ireset     (ireset),
        .iclkena    (iclkena),
        .ibuf_full  (ibuf_full),
        .ilen       (ilen),
        .itag       (itag),
        .obuf_empty (obuf_empty),
        .oraddr     (oraddr),
        .oread      (oread),
        .irdat      (irdat),
        .ireq       (ireq),
        .oval       (oval),
        .osop       (osop),
        .oeop       (oeop),
        .odat       (odat),
        .otag       (otag),
        .obusy      (obusy)
    );

    // Buffer RAM with a fixed read latency counted in enabled ticks.
    always @(posedge iclk) begin
        if (iclkena) begin
            ramPipe[0] <= ram[oraddr];
            for (int i = 1; i < LAT; i++) ramPipe[i] <= ramPipe[i-1];
        end
    end
    assign irdat = ramPipe[LAT-1];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s actual=timeout expected=event", name);
    endtask

    task automatic checkResetOutputs(input string tagName);
        checkOutput({tagName, "_oval"}, 32'(oval), 0);
        checkOutput({tagName, "_osop"}, 32'(osop), 0);
        checkOutput({tagName, "_oeop"}, 32'(oeop), 0);
        checkOutput({tagName, "_oread"}, 32'(oread), 0);
        checkOutput({tagName, "_obuf_empty"}, 32'(obuf_empty), 0);
        checkOutput({tagName, "_obusy"}, 32'(obusy), 0);
        checkOutput({tagName, "_oraddr"}, 32'(oraddr), 0);
        checkOutput({tagName, "_odat"}, 32'(odat), 0);
        checkOutput({tagName, "_otag"}, 32'(otag), 0);
    endtask

    task automatic loadFrame(input int len, input logic [TW-1:0] tag);
        for (int i = 0; i <= len; i++) begin
            ram[i] = 8'($urandom);
            expQ.push_back('{dat: ram[i], sop: (i == 0), eop: (i == len), tag: tag});
        end
        ilen = AW'(len);
        itag = tag;
    endtask

    // Streams nFrames codewords with ibuf_full held across frame boundaries.
    task automatic applyStimulus(input int nFrames, input int len, input int mode, input int ena,
                                 input logic [TW-1:0] tagA, input logic [TW-1:0] tagB);
        int base, n;
        base = pulseCnt;
        reqMode = mode;
        enaRandom = ena;
        holdStart = cyc + 15;
        for (int k = 0; k < nFrames; k++) begin
            loadFrame(len, (k == 0) ? tagA : tagB);
            ibuf_full = 1'b1;
            n = 0;
            while (pulseCnt < base + k + 1 && n < 3000) begin
                @(posedge iclk); #2;
                n++;
            end
            if (pulseCnt < base + k + 1) begin
                failNow("obuf_empty_wait");
                ibuf_full = 1'b0;
                expQ.delete();
                return;
            end
        end
        ibuf_full = 1'b0;
        n = 0;
        while ((expQ.size() != 0 || obusy) && n < 3000) begin
            @(posedge iclk); #2;
            n++;
        end
        if (expQ.size() != 0 || obusy) begin
            failNow("drain_wait");
            expQ.delete();
        end
        repeat (4) @(posedge iclk);
        #2;
        checkOutput("pulse_count", 32'(pulseCnt), 32'(base + nFrames));
        checkOutput("idle_oval", 32'(oval), 0);
        checkOutput("idle_obusy", 32'(obusy), 0);
    endtask

    task automatic resetMidFrame();
        int base, pulses, n;
        reqMode = 0;
        enaRandom = 0;
        base = acceptCnt;
        pulses = pulseCnt;
        loadFrame(31, 4'd5);
        ibuf_full = 1'b1;
        n = 0;
        while (acceptCnt < base + 7 && n < 500) begin
            @(posedge iclk); #2;
            n++;
        end
        if (acceptCnt < base + 7) failNow("reset_word7_wait");
        ireset = 1'b1;
        ibuf_full = 1'b0;
        expQ.delete();
        @(negedge iclk);
        checkResetOutputs("midreset");
        repeat (3) @(posedge iclk);
        #2;
        ireset = 1'b0;
        checkOutput("midreset_no_pulse", 32'(pulseCnt), 32'(pulses));
    endtask

    // Downstream ready and clock-enable drivers.
    initial begin
        forever begin
            @(posedge iclk);
            #1;
            cyc++;
            case (reqMode)
                0: ireq = 1'b1;
                1: ireq = ~ireq;
                2: ireq = ($urandom_range(0, 3) != 0);
                default: ireq = !(cyc >= holdStart && cyc < holdStart + 50);
            endcase
            iclkena = (enaRandom != 0) ? ($urandom_range(0, 4) != 0) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every accepted word.
    initial begin
        exp_t e;
        bit accept, rd;
        forever begin
            @(negedge iclk);
            if (ireset) begin
                outstanding = 0;
                checkBusyLow = 0;
                holdPending = 0;
                prevEmpty = 0;
            end else begin
                if (checkBusyLow) begin
                    checkOutput("obusy_clear", 32'(obusy), 0);
                    checkBusyLow = 0;
                end
                if (prevEmpty && enaPrev) checkOutput("obuf_empty_width", 32'(obuf_empty), 0);
                if (obuf_empty && !prevEmpty) pulseCnt++;
                prevEmpty = obuf_empty;
                if (holdPending && oval) begin
                    checkOutput("hold_odat", 32'(odat), 32'(holdDat));
                    checkOutput("hold_strb", {30'd0, osop, oeop}, {30'd0, holdSop, holdEop});
                end
                rd = oread && iclkena;
                accept = oval && ireq && iclkena;
                if (rd) checkOutput("credit_limit", 32'(outstanding < 4), 1);
                if (accept) begin
                    acceptCnt++;
                    if (expQ.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL unexpected_word actual=%0h expected=none", odat);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("odat", 32'(odat), 32'(e.dat));
                        checkOutput("osop", 32'(osop), 32'(e.sop));
                        checkOutput("oeop", 32'(oeop), 32'(e.eop));
                        checkOutput("otag", 32'(otag), 32'(e.tag));
                        checkOutput("obusy_active", 32'(obusy), 1);
                        if (e.eop) begin
                            checkOutput("pulse_before_eop", 32'(pulseCnt), 32'(eopSeen + 1));
                            eopSeen++;
                            checkBusyLow = 1;
                        end
                    end
                end
                holdPending = oval && !accept;
                holdDat = odat;
                holdSop = osop;
                holdEop = oeop;
                outstanding = outstanding + int'(rd) - int'(accept);
            end
            enaPrev = iclkena;
        end
    end

    initial begin
        int nf, len;
        repeat (3) @(negedge iclk);
        checkResetOutputs("reset");
        @(posedge iclk); #2;
        ireset = 1'b0;
        repeat (3) @(posedge iclk);
        #2;
        $display("[TB] 16-word frame, ireq high");
        applyStimulus(1, 15, 0, 0, 4'd6, 4'd6);
        $display("[TB] 16-word frame, ireq toggling");
        applyStimulus(1, 15, 1, 0, 4'd2, 4'd2);
        $display("[TB] single-word frame");
        applyStimulus(1, 0, 0, 0, 4'd11, 4'd11);
        $display("[TB] 32-word frame, 50-tick stall");
        applyStimulus(1, 31, 3, 0, 4'd7, 4'd7);
        $display("[TB] back-to-back frames tags 3,9");
        applyStimulus(2, 15, 0, 0, 4'd3, 4'd9);
        $display("[TB] reset mid-frame then recovery");
        resetMidFrame();
        repeat (3) @(posedge iclk);
        #2;
        applyStimulus(1, 31, 0, 0, 4'd12, 4'd12);
        $display("[TB] random frames with random enable and ready");
        for (int t = 0; t < 6; t++) begin
            nf = $urandom_range(1, 3);
            len = $urandom_range(0, 40);
            applyStimulus(nf, len, 2, 1, 4'($urandom), 4'($urandom));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout actual=running expected=finished");
        $fatal(1, "[TB] global timeout");
    end

endmodule

// File: doc/ldpc_dvb_enc_sink.md
Name: ldpc_dvb_enc_sink

Overview:
- Downstream stage of the encoder controller. Drains one encoded codeword (data + parity words) from the encoder output ping-pong buffer and streams it to the user interface with a valid/ready handshake.
- Reports buffer release (`obuf_empty`), which drives the controller's `iobuf_empty` input.
- A 4-entry skid FIFO absorbs the fixed RAM read latency, so back-pressure never loses a word.

Parameters:
- pDAT_W, 8, output word width in bits
- pADDR_W, 12, output buffer read address width
- pRD_LAT, 2, fixed buffer read latency in clocks (legal range 1..2)
- pTAG_W, 4, frame tag width

Ports:
- iclk  in  1  clock
- ireset  in  1  asynchronous reset, active high
- iclkena  in  1  clock enable; all registers hold when low
- ibuf_full  in  1  output buffer bank holds a complete codeword
- ilen  in  pADDR_W  codeword length in words, minus 1; sampled in cINIT_STATE
- itag  in  pTAG_W  frame tag; sampled in cINIT_STATE
- obuf_empty  out  1  one-tick pulse: bank fully read, may be swapped
- oraddr  out  pADDR_W  buffer read address
- oread  out  1  buffer read strobe
- irdat  in  pDAT_W  buffer read data, valid pRD_LAT ticks after oread
- ireq  in  1  downstream ready
- oval  out  1  output word valid
- osop  out  1  first word of frame
- oeop  out  1  last word of frame
- odat  out  pDAT_W  output word
- otag  out  pTAG_W  frame tag, constant for the whole frame
- obusy  out  1  frame in progress (from cINIT_STATE until last word accepted)

Behaviour:
- Reset: state = cRESET_STATE. oval, osop, oeop, oread, obuf_empty, obusy = 0. oraddr, odat, otag = 0. FIFO count = 0. Pipeline valid bits = 0.
- Reset mid-frame aborts the frame immediately. No partial `obuf_empty` pulse is issued.
- FSM transitions:
  - cRESET_STATE -> cWAIT_STATE.
  - cWAIT_STATE -> cINIT_STATE when ibuf_full.
  - cINIT_STATE: latch ilen and itag; clear address counter -> cREAD_STATE.
  - cREAD_STATE: issue reads while credit allows. Move to cFLUSH_STATE the tick after the read at address == len is issued.
  - cFLUSH_STATE: wait until pipeline and FIFO are empty and the last word is accepted -> cDONE_STATE.
  - cDONE_STATE -> cWAIT_STATE.
- Credit rule: oread = (state == cREAD_STATE) and (fifo_cnt + inflight < 4). inflight = number of reads still inside the pRD_LAT delay line. fifo_cnt must never exceed 4.
- Read data handling: the pRD_LAT-deep valid/sop/eop delay line tags each returning word. osop is tagged on address 0; oeop on address len. The returning word is pushed into the FIFO.
- Output handshake: oval = FIFO not empty. A word is accepted when oval & ireq. odat/osop/oeop/otag come from the FIFO head, registered (show-ahead). oval may assert regardless of ireq; the outputs hold stable while oval & !ireq.
- Simultaneous FIFO push and pop in the same tick: count is unchanged.
- obuf_empty pulses for 1 tick the tick after the eop word is pushed into the FIFO. Buffer contents are no longer needed at that point. This pulse is issued before the eop word is accepted downstream.
- obusy clears the tick after the eop word is accepted.
- Length rule: ilen == 0 is a legal 1-word frame; osop and oeop are both set on that word.
- Back-to-back frames: if ibuf_full is already high on return to cWAIT_STATE, the next cINIT_STATE follows with 1 idle tick. A minimum 3-tick gap between frames at the read side is accepted.
- iclkena low: FSM, counters, FIFO and delay line freeze. The external RAM follows the same enable, so latency is counted in enabled ticks.

Decomposition:
- Shared encoder types header gains:
  - `sink_strb_t` (sop, eop)
  - skid depth constant cSINK_FIFO_DEPTH = 4
  - `buf_addr_t` (pADDR_W)
- Sub-module `ldpc_dvb_enc_sink_fifo`: 4-entry register FIFO carrying data, sop, eop; show-ahead; count output. Instantiated once.
- The FSM and read delay line stay in the top.

Test Plan:
- ilen = 15, ireq always 1, pRD_LAT = 2 -> 16 consecutive words after a 4-tick startup. osop on word 0, oeop on word 15. obuf_empty is a single pulse. otag equals the sampled itag.
- ilen = 15, ireq toggling 1-0-1-0 -> same 16 words in order, none lost or duplicated. fifo_cnt never exceeds 4. oread is throttled.
- ilen = 0 -> one word with osop = oeop = 1, one obuf_empty pulse, obusy high for that frame only.
- ireq held 0 for 50 ticks mid-frame (ilen = 31) -> oread stops after 4 credits. Outputs are held stable. Resume gives contiguous data 0..31.
- Two frames, ibuf_full kept high, tags 3 then 9 -> the second frame's osop follows the first oeop with no overlap. otag changes only at the frame boundary. Two obuf_empty pulses.
- ireset asserted at word 7 of a 32-word frame -> all outputs 0 next tick, no obuf_empty. After release, the next full frame streams correctly.
